// File: rtl/uncached_write_buffer.sv
// uncached_write_buffer: FIFO of uncached stores drained as single-beat AXI writes.
// Revision: 1.0
`default_nettype none

module uncached_write_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        wb_push_valid,
  output logic        wb_push_ready,
  input  logic [31:0] wb_push_addr,
  input  logic [31:0] wb_push_data,
  input  logic [3:0]  wb_push_strb,
  input  logic [2:0]  wb_push_size,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  input  logic [31:0] rd_check_addr,
  output logic        rd_conflict,
  output logic        wb_empty,
  output logic        wb_full,
  output logic [CW-1:0] wb_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, RESP = 2'd2} state_t;

  state_t          state;
  logic [31:0]     addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [3:0]      strb_q [DEPTH];
  logic [2:0]      size_q [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic            aw_done, w_done;
  logic            push, pop, aw_hs, w_hs;
  logic            unused_bits;

  assign wb_full       = (count == CW'(DEPTH));
  assign wb_empty      = (count == '0);
  assign wb_count      = count;
  assign wb_push_ready = !wb_full;

  assign push      = wb_push_valid && wb_push_ready;
  assign pop       = bvalid && bready;
  assign count_nxt = count + CW'(push) - CW'(pop);

  assign awvalid = (state == SEND) && !aw_done;
  assign wvalid  = (state == SEND) && !w_done;
  assign bready  = (state == RESP);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // Head entry is held until the response pops it, so channel payloads stay stable.
  assign awaddr = addr_q[rd_ptr];
  assign awsize = size_q[rd_ptr];
  assign awlen  = 8'd0;
  assign wdata  = data_q[rd_ptr];
  assign wstrb  = strb_q[rd_ptr];
  assign wlast  = 1'b1;

  assign unused_bits = ^rd_check_addr[1:0];

  always_ff @(posedge aclk) begin
    if (push) begin
      addr_q[wr_ptr] <= wb_push_addr;
      data_q[wr_ptr] <= wb_push_data;
      strb_q[wr_ptr] <= wb_push_strb;
      size_q[wr_ptr] <= wb_push_size;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      count <= count_nxt;
      case (state)
        IDLE: if (count != '0 || push) state <= SEND;
        SEND: begin
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state   <= RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        RESP: if (bvalid) state <= (count_nxt != '0) ? SEND : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (addr_q[i][31:2] == rd_check_addr[31:2])) rd_conflict = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uncached_write_buffer.sv
// tb_uncached_write_buffer: directed self-checking bench for uncached_write_buffer.
// Revision: 1.0
`default_nettype none

module tb_uncached_write_buffer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        wb_push_valid, wb_push_ready;
  logic [31:0] wb_push_addr, wb_push_data;
  logic [3:0]  wb_push_strb;
  logic [2:0]  wb_push_size;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bvalid, bready;
  logic [31:0] rd_check_addr;
  logic        rd_conflict, wb_empty, wb_full;
  logic [2:0]  wb_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_addr [4];
  logic [31:0] exp_data [4];

  always #5 aclk = ~aclk;

  uncached_write_buffer #(.DEPTH(4), .CW(3)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .wb_push_valid(wb_push_valid), .wb_push_ready(wb_push_ready),
    .wb_push_addr(wb_push_addr), .wb_push_data(wb_push_data),
    .wb_push_strb(wb_push_strb), .wb_push_size(wb_push_size),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .rd_check_addr(rd_check_addr), .rd_conflict(rd_conflict),
    .wb_empty(wb_empty), .wb_full(wb_full), .wb_count(wb_count)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_set(input logic [31:0] a, input logic [31:0] d);
    wb_push_valid = 1'b1;
    wb_push_addr  = a;
    wb_push_data  = d;
    wb_push_strb  = 4'hF;
    wb_push_size  = 3'd2;
  endtask

  initial begin
    aresetn = 1'b0; wb_push_valid = 1'b0; wb_push_addr = '0; wb_push_data = '0;
    wb_push_strb = '0; wb_push_size = '0; awready = 1'b0; wready = 1'b0;
    bvalid = 1'b0; rd_check_addr = '0;
    tick(); tick();
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_bready", 32'(bready), 32'd0);
    chk("rst_empty", 32'(wb_empty), 32'd1);
    chk("rst_full", 32'(wb_full), 32'd0);
    chk("rst_count", 32'(wb_count), 32'd0);
    chk("rst_conflict", 32'(rd_conflict), 32'd0);
    chk("rst_push_ready", 32'(wb_push_ready), 32'd1);

    // Single store, both channels ready, response one cycle later.
    aresetn = 1'b1; tick();
    awready = 1'b1; wready = 1'b1;
    push_set(32'h1FAF_F000, 32'hDEAD_BEEF);
    tick();
    wb_push_valid = 1'b0;
    chk("s_awvalid", 32'(awvalid), 32'd1);
    chk("s_wvalid", 32'(wvalid), 32'd1);
    chk("s_awaddr", awaddr, 32'h1FAF_F000);
    chk("s_wdata", wdata, 32'hDEAD_BEEF);
    chk("s_wstrb", 32'(wstrb), 32'hF);
    chk("s_awsize", 32'(awsize), 32'd2);
    chk("s_awlen", 32'(awlen), 32'd0);
    chk("s_wlast", 32'(wlast), 32'd1);
    chk("s_count", 32'(wb_count), 32'd1);
    tick();
    chk("s_resp_awvalid", 32'(awvalid), 32'd0);
    chk("s_resp_wvalid", 32'(wvalid), 32'd0);
    chk("s_resp_bready", 32'(bready), 32'd1);
    bvalid = 1'b1; tick(); bvalid = 1'b0;
    chk("s_empty", 32'(wb_empty), 32'd1);
    chk("s_idle_bready", 32'(bready), 32'd0);
    chk("s_idle_awvalid", 32'(awvalid), 32'd0);

    // Fill with AXI stalled; first entry also exercises the read-conflict check.
    awready = 1'b0; wready = 1'b0;
    exp_addr[0] = 32'h1FD0_0004; exp_data[0] = 32'h1111_0000;
    exp_addr[1] = 32'h1000_0010; exp_data[1] = 32'h2222_0001;
    exp_addr[2] = 32'h1000_0020; exp_data[2] = 32'h3333_0002;
    exp_addr[3] = 32'h1000_0030; exp_data[3] = 32'h4444_0003;
    push_set(exp_addr[0], exp_data[0]); tick();
    rd_check_addr = 32'h1FD0_0006; #1;
    chk("conf_hit", 32'(rd_conflict), 32'd1);
    rd_check_addr = 32'h1FD0_0008; #1;
    chk("conf_miss", 32'(rd_conflict), 32'd0);
    for (int k = 1; k < 4; k++) begin
      push_set(exp_addr[k], exp_data[k]); tick();
    end
    chk("fill_full", 32'(wb_full), 32'd1);
    chk("fill_ready", 32'(wb_push_ready), 32'd0);
    chk("fill_count", 32'(wb_count), 32'd4);
    push_set(32'h1000_0040, 32'h5555_0004); tick();
    chk("stall_count", 32'(wb_count), 32'd4);

    // W completes first; AW follows three cycles later.
    wready = 1'b1; tick(); wready = 1'b0;
    chk("wf_wvalid", 32'(wvalid), 32'd0);
    chk("wf_awvalid", 32'(awvalid), 32'd1);
    chk("wf_bready", 32'(bready), 32'd0);
    tick(); tick();
    chk("wf_awvalid_hold", 32'(awvalid), 32'd1);
    chk("wf_awaddr_hold", awaddr, exp_addr[0]);
    chk("wf_bready_hold", 32'(bready), 32'd0);
    awready = 1'b1; tick(); awready = 1'b0;
    chk("wf_bready_now", 32'(bready), 32'd1);
    chk("wf_awvalid_off", 32'(awvalid), 32'd0);

    // Pop while full with a push held: push waits one cycle.
    bvalid = 1'b1; tick(); bvalid = 1'b0;
    chk("pf_count3", 32'(wb_count), 32'd3);
    chk("pf_ready", 32'(wb_push_ready), 32'd1);
    tick();
    wb_push_valid = 1'b0;
    chk("pf_count4", 32'(wb_count), 32'd4);
    chk("pf_full", 32'(wb_full), 32'd1);

    // Drain in push order.
    exp_addr[0] = 32'h1000_0040; exp_data[0] = 32'h5555_0004;
    awready = 1'b1; wready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      chk("dr_awaddr", awaddr, exp_addr[k % 4]);
      chk("dr_wdata", wdata, exp_data[k % 4]);
      tick();
      chk("dr_bready", 32'(bready), 32'd1);
      bvalid = 1'b1; tick(); bvalid = 1'b0;
      chk("dr_count", 32'(wb_count), 32'(4 - k));
    end
    chk("dr_empty", 32'(wb_empty), 32'd1);

    // Reset while waiting for a response with three entries.
    awready = 1'b0; wready = 1'b0;
    push_set(32'h2000_0000, 32'hA0A0_A0A0); tick();
    push_set(32'h2000_0004, 32'hB0B0_B0B0); tick();
    push_set(32'h2000_0008, 32'hC0C0_C0C0); tick();
    wb_push_valid = 1'b0;
    awready = 1'b1; wready = 1'b1; tick(); awready = 1'b0; wready = 1'b0;
    chk("rr_bready", 32'(bready), 32'd1);
    chk("rr_count3", 32'(wb_count), 32'd3);
    aresetn = 1'b0; tick(); aresetn = 1'b1;
    chk("rr_count", 32'(wb_count), 32'd0);
    chk("rr_awvalid", 32'(awvalid), 32'd0);
    chk("rr_wvalid", 32'(wvalid), 32'd0);
    chk("rr_bready0", 32'(bready), 32'd0);
    bvalid = 1'b1; tick(); bvalid = 1'b0;
    chk("rr_late_count", 32'(wb_count), 32'd0);
    chk("rr_late_awvalid", 32'(awvalid), 32'd0);
    chk("rr_late_empty", 32'(wb_empty), 32'd1);
    rd_check_addr = 32'h2000_0004; #1;
    chk("rr_conflict", 32'(rd_conflict), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/uncached_write_buffer.md
UNCACHED_WRITE_BUFFER -- requirements
Module: uncached_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 SHALL have parameter CW, default 3, width of wb_count (log2(DEPTH)+1).
REQ-003 SHALL have aclk input 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have aresetn input 1: synchronous, active-low reset, sampled on the aclk rising edge.
REQ-005 SHALL have wb_push_valid input 1: uncached store request from d_cache.
REQ-006 SHALL have wb_push_ready output 1: the buffer accepts the store this cycle.
REQ-007 SHALL have wb_push_addr input 32: physical byte address.
REQ-008 SHALL have wb_push_data input 32: store data.
REQ-009 SHALL have wb_push_strb input 4: byte strobes.
REQ-010 SHALL have wb_push_size input 3: AXI size code.
REQ-011 SHALL have awaddr, awlen, awsize, awvalid outputs 32/8/3/1, and awready input 1: AXI write-address channel.
REQ-012 SHALL have wdata, wstrb, wlast, wvalid outputs 32/4/1/1, and wready input 1: AXI write-data channel.
REQ-013 SHALL have bvalid input 1 and bready output 1: AXI write-response channel.
REQ-014 SHALL have rd_check_addr input 32: address of a pending uncached load.
REQ-015 SHALL have rd_conflict output 1: rd_check_addr word-matches a valid entry.
REQ-016 SHALL have wb_empty output 1, wb_full output 1 and wb_count output CW: occupancy status.

Function
REQ-017 SHALL hold a circular FIFO of DEPTH entries {addr, data, strb, size}, with a write pointer, a read pointer and a CW-bit count.
REQ-018 SHALL drive wb_push_ready = !wb_full; a push SHALL occur when wb_push_valid && wb_push_ready.
REQ-019 SHALL drive wb_full = (count == DEPTH) and wb_empty = (count == 0), combinationally from count.
REQ-020 SHALL pop the head entry only on the cycle bvalid && bready.
REQ-021 SHALL leave count unchanged on a simultaneous push and pop; when full, no push SHALL occur that cycle, even if a pop occurs.
REQ-022 SHALL wrap the pointers modulo DEPTH.
REQ-023 SHALL run a FIFO state machine with states IDLE, SEND and RESP.
REQ-024 IDLE SHALL move to SEND when count != 0, or the cycle after a push into an empty buffer (1-cycle minimum latency from push to awvalid).
REQ-025 In SEND, awvalid and wvalid SHALL assert together from the head entry; awlen = 0, wlast = 1, awsize = head size.
REQ-026 In SEND, aw_done and w_done flags SHALL each deassert their valid after its handshake; either channel may complete first, or both in the same cycle.
REQ-027 SEND SHALL move to RESP when both channels have completed; the flags SHALL clear on entry to RESP.
REQ-028 In RESP, bready SHALL be 1; on bvalid the FSM SHALL pop the entry and go to SEND if count after the pop != 0, else to IDLE.
REQ-029 awaddr, wdata and wstrb SHALL stay stable while their valid is high.
REQ-030 rd_conflict SHALL be combinational: 1 if any valid entry (including the one in flight) has addr[31:2] == rd_check_addr[31:2].
REQ-031 SHALL allow only one outstanding AXI write at a time; bresp is ignored.

Reset
REQ-032 While aresetn = 0 at a clock edge: state SHALL be IDLE, pointers and count 0, aw_done and w_done 0.
REQ-033 During reset the outputs SHALL be awvalid = 0, wvalid = 0, bready = 0, wb_empty = 1, wb_full = 0, wb_count = 0, rd_conflict = 0 and wb_push_ready = 1.
REQ-034 Reset mid-transaction SHALL discard all entries with no further AXI activity; entry storage need not be cleared.

Verification
REQ-035 Single push addr 0x1FAF_F000, data 0xDEAD_BEEF, strb 0xF, awready = wready = 1, bvalid one cycle later -> awvalid and wvalid high on cycle 1 after push; wb_empty = 1 after bvalid.
REQ-036 Four back-to-back pushes with awready held 0 -> wb_full = 1 and wb_push_ready = 0 after the 4th; a 5th push is stalled; AXI order matches push order.
REQ-037 wready before awready (3 cycles apart) -> wvalid drops after its handshake, awvalid holds until awready, and only then does bready assert.
REQ-038 Buffer full with a push held valid while bvalid pops -> the push is not accepted that cycle, is accepted next cycle, and wb_count returns to 4.
REQ-039 Entry at 0x1FD0_0004 pending, rd_check_addr = 0x1FD0_0006 -> rd_conflict = 1; rd_check_addr = 0x1FD0_0008 -> rd_conflict = 0.
REQ-040 aresetn = 0 in RESP with 3 entries -> next cycle wb_count = 0, awvalid = wvalid = bready = 0; a late bvalid is ignored.
